// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared states, instruction classes, opcodes and ALUOp codes for the main control FSM
package cpu_ctrl_pkg;
  localparam int ALUOP_W = 2;
  localparam int OPC_W = 11;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {C_RTYPE, C_ADDI, C_LOAD, C_STORE, C_CBZ, C_BCOND, C_B, C_ILL} iclass_e;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_PASSB = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [OPC_W-1:0] OPC_ADDS = 11'b10101011000;
  localparam logic [OPC_W-1:0] OPC_SUBS = 11'b11101011000;
  localparam logic [OPC_W-1:0] OPC_AND = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_LSR = 11'b11010011010;
  localparam logic [OPC_W-1:0] OPC_LSL = 11'b11010011011;
  localparam logic [OPC_W-1:0] OPC_MUL = 11'b10011011000;
  localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
  localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
  localparam logic [OPC_W-1:0] OPC_ADDI = 11'b1001000100x;
  localparam logic [OPC_W-1:0] OPC_CBZ = 11'b10110100xxx;
  localparam logic [OPC_W-1:0] OPC_BCOND = 11'b01010100xxx;
  localparam logic [OPC_W-1:0] OPC_B = 11'b000101xxxxx;
  function automatic logic sets_flags(input logic [OPC_W-1:0] opc);
    return opc == OPC_ADDS || opc == OPC_SUBS;
  endfunction
endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: combinational map from the 11-bit opcode field to an instruction class
module opcode_classifier
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output iclass_e          iclass_o
);
  assign iclass_o = (opcode_i inside {OPC_ADDS, OPC_SUBS, OPC_AND, OPC_LSR, OPC_LSL, OPC_MUL}) ? C_RTYPE :
                    (opcode_i ==? OPC_ADDI)  ? C_ADDI  :
                    (opcode_i == OPC_LDUR)   ? C_LOAD  :
                    (opcode_i == OPC_STUR)   ? C_STORE :
                    (opcode_i ==? OPC_CBZ)   ? C_CBZ   :
                    (opcode_i ==? OPC_BCOND) ? C_BCOND :
                    (opcode_i ==? OPC_B)     ? C_B     : C_ILL;
endmodule

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: fetch/decode/exec/mem/wb sequencer driving ALUOp, datapath enables and memory handshakes
module multicycle_main_control
  import cpu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic [31:0]        instr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  input  logic               zero,
  input  logic               cond_true,
  output logic [OPC_W-1:0]   opcode_field,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg2loc,
  output logic               alu_src,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               dmem_req,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_branch,
  output logic               flags_write,
  output logic               illegal
);
  state_e state_q, state_d;
  logic [OPC_W-1:0] ir_q, ir_d;
  logic illegal_q, illegal_d;
  iclass_e cls;
  logic fetch_s, exec_s, mem_s, wb_s;
  logic unused_instr;
  assign unused_instr = ^instr[20:0];
  opcode_classifier u_cls (.opcode_i(ir_q), .iclass_o(cls));
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = imem_ack ? S_DECODE : run ? S_FETCH : S_IDLE;
      S_DECODE: state_d = (cls == C_ILL) ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (cls inside {C_RTYPE, C_ADDI}) ? S_WB :
                          (cls inside {C_LOAD, C_STORE}) ? S_MEM : S_FETCH;
      S_MEM:    state_d = !dmem_ack ? S_MEM : (cls == C_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end
  assign ir_d = (fetch_s && imem_ack) ? instr[31:21] : ir_q;
  assign illegal_d = illegal_q | (state_q == S_DECODE && cls == C_ILL);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      ir_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      illegal_q <= illegal_d;
    end
  assign fetch_s = state_q == S_FETCH;
  assign exec_s = state_q == S_EXEC;
  assign mem_s = state_q == S_MEM;
  assign wb_s = state_q == S_WB;
  assign opcode_field = ir_q;
  assign imem_req = fetch_s;
  assign ir_write = fetch_s && imem_ack;
  // WB keeps the EXEC ALU setup so the write-back value stays stable
  assign alu_op = ((exec_s || wb_s) && (cls inside {C_RTYPE, C_ADDI})) ? ALUOP_RTYPE :
                  (exec_s && cls == C_CBZ) ? ALUOP_PASSB : ALUOP_ADD;
  assign alu_src = mem_s || (exec_s && (cls inside {C_ADDI, C_LOAD, C_STORE})) ||
                   (wb_s && (cls inside {C_ADDI, C_LOAD}));
  assign reg2loc = exec_s && (cls inside {C_STORE, C_CBZ});
  assign mem_to_reg = wb_s && cls == C_LOAD;
  assign reg_write = wb_s;
  assign dmem_req = mem_s;
  assign mem_read = mem_s && cls == C_LOAD;
  assign mem_write = mem_s && cls == C_STORE;
  assign pc_write = wb_s || (exec_s && (cls inside {C_CBZ, C_BCOND, C_B})) ||
                    (mem_s && cls == C_STORE && dmem_ack);
  assign pc_branch = exec_s && ((cls == C_CBZ) ? zero : (cls == C_BCOND) ? cond_true : cls == C_B);
  assign flags_write = exec_s && cls == C_RTYPE && sets_flags(ir_q);
  assign illegal = illegal_q;
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: instruction-level trace model checked against the DUT every cycle
module tb_multicycle_main_control;
  logic clk = 1'b0, reset_n = 1'b0, run = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic zero = 1'b0, cond_true = 1'b0;
  logic [31:0] instr = '0;
  logic imem_req, reg2loc, alu_src, mem_to_reg, reg_write, dmem_req, mem_read, mem_write;
  logic ir_write, pc_write, pc_branch, flags_write, illegal;
  logic [10:0] opcode_field;
  logic [1:0] alu_op;

  multicycle_main_control dut (
    .clk(clk), .reset_n(reset_n), .run(run), .instr(instr), .imem_req(imem_req),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .zero(zero), .cond_true(cond_true),
    .opcode_field(opcode_field), .alu_op(alu_op), .reg2loc(reg2loc), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .dmem_req(dmem_req), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write), .pc_branch(pc_branch),
    .flags_write(flags_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic imem_req, ir_write;
    logic [1:0] alu_op;
    logic reg2loc, alu_src, mem_to_reg, reg_write, dmem_req, mem_read, mem_write;
    logic pc_write, pc_branch, flags_write, illegal;
    logic [10:0] opc;
  } ov_t;
  typedef struct packed {
    logic r, ia, da, z, c;
    logic [31:0] ins;
  } st_t;

  ov_t act, exp_v;
  assign act = {imem_req, ir_write, alu_op, reg2loc, alu_src, mem_to_reg, reg_write, dmem_req,
                mem_read, mem_write, pc_write, pc_branch, flags_write, illegal, opcode_field};

  ov_t expq[$];
  int n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0, gap = 0, pc_cnt = 0, rw_cnt = 0, rd_cnt = 0, n = 0;
  logic prev_req = 1'b0;
  logic [10:0] cur_opc = '0;
  logic halted = 1'b0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (imem_req && !prev_req) gap = cyc - acc_cyc;
    if (ir_write) acc_cyc = cyc;
    prev_req = imem_req;
    pc_cnt += int'(pc_write);
    rw_cnt += int'(reg_write);
    rd_cnt += int'(mem_read);
    if (expq.size() > 0) begin
      exp_v = expq.pop_front();
      chk($sformatf("cycle%0d outputs", cyc), 32'(act), 32'(exp_v));
    end
  end

  function automatic int cls_of(input logic [10:0] o);
    if (o == 11'b10101011000 || o == 11'b11101011000 || o == 11'b10001010000 ||
        o == 11'b11010011010 || o == 11'b11010011011 || o == 11'b10011011000) return 0;
    if (o[10:1] == 10'b1001000100) return 1;
    if (o == 11'b11111000010) return 2;
    if (o == 11'b11111000000) return 3;
    if (o[10:3] == 8'b10110100) return 4;
    if (o[10:3] == 8'b01010100) return 5;
    if (o[10:5] == 6'b000101) return 6;
    return 7;
  endfunction

  function automatic ov_t base();
    ov_t e = '0;
    e.opc = cur_opc;
    e.illegal = halted;
    return e;
  endfunction

  function automatic st_t mk(input logic r, input logic ia, input logic da);
    return {r, ia, da, 1'b0, 1'b0, 32'h0};
  endfunction

  task automatic cycle(input st_t s, input ov_t e);
    @(posedge clk);
    #1;
    run = s.r; imem_ack = s.ia; dmem_ack = s.da; zero = s.z; cond_true = s.c; instr = s.ins;
    expq.push_back(e);
  endtask

  task automatic idle(input logic r);
    cycle(mk(r, 1'b0, 1'b0), base());
  endtask

  task automatic stop_fetch();
    ov_t e = base();
    e.imem_req = 1'b1;
    cycle(mk(1'b0, 1'b0, 1'b0), e);
  endtask

  // One instruction from its fetch cycle onward; abort >= 0 cuts the MEM phase short for a reset
  task automatic do_instr(input logic [31:0] ins, input logic z, input logic c, input int dwait,
                          input logic stale, input int abort, output int cnt);
    ov_t e;
    st_t s;
    logic [10:0] o;
    int cl;
    o = ins[31:21];
    cl = cls_of(o);
    cnt = 0;
    s = {1'b1, 1'b1, 1'b0, z, c, ins};
    e = base(); e.imem_req = 1'b1; e.ir_write = 1'b1;
    cycle(s, e); cnt++;
    cur_opc = o;
    s.ia = stale; s.da = stale;
    cycle(s, base()); cnt++;
    if (cl == 7) begin
      halted = 1'b1;
      return;
    end
    e = base();
    case (cl)
      0: begin e.alu_op = 2'b10; e.flags_write = (o == 11'b10101011000 || o == 11'b11101011000); end
      1: begin e.alu_op = 2'b10; e.alu_src = 1'b1; end
      2: e.alu_src = 1'b1;
      3: begin e.alu_src = 1'b1; e.reg2loc = 1'b1; end
      4: begin e.alu_op = 2'b01; e.reg2loc = 1'b1; e.pc_write = 1'b1; e.pc_branch = z; end
      5: begin e.pc_write = 1'b1; e.pc_branch = c; end
      default: begin e.pc_write = 1'b1; e.pc_branch = 1'b1; end
    endcase
    cycle(s, e); cnt++;
    if (cl == 2 || cl == 3)
      for (int k = 0; k <= dwait; k++) begin
        e = base(); e.alu_src = 1'b1; e.dmem_req = 1'b1;
        e.mem_read = (cl == 2); e.mem_write = (cl == 3); e.pc_write = (cl == 3 && k == dwait);
        s.da = (k == dwait);
        if (k == abort) begin
          s.da = 1'b0;
          cycle(s, '0);
          return;
        end
        cycle(s, e); cnt++;
      end
    s.da = stale;
    if (cl <= 2) begin
      e = base(); e.reg_write = 1'b1; e.pc_write = 1'b1; e.mem_to_reg = (cl == 2);
      e.alu_op = (cl < 2) ? 2'b10 : 2'b00; e.alu_src = (cl != 0);
      cycle(s, e); cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0; cur_opc = '0; halted = 1'b0;
    #1;
    chk("async reset outputs", 32'(act), 32'h0);
    chk("async reset illegal", 32'(illegal), 32'h0);
    cycle(mk(1'b0, 1'b1, 1'b1), '0);
    cycle(mk(1'b0, 1'b0, 1'b0), '0);
    reset_n = 1'b1;
  endtask

  initial begin
    ov_t e;
    repeat (2) @(negedge clk);
    chk("reset outputs", 32'(act), 32'h0);
    reset_n = 1'b1;
    idle(1'b0);
    idle(1'b1);
    e = base(); e.imem_req = 1'b1;
    cycle(mk(1'b1, 1'b0, 1'b0), e);
    cycle(mk(1'b0, 1'b0, 1'b0), e);
    idle(1'b0);
    idle(1'b1);
    do_instr(32'hAB020020, 1'b0, 1'b0, 0, 1'b0, -1, n);
    chk("adds cycle count", n, 4);
    #1 chk("adds opcode_field", 32'(opcode_field), 32'(11'b10101011000));
    do_instr(32'hEB020020, 1'b0, 1'b0, 0, 1'b1, -1, n);
    do_instr(32'h8A000000, 1'b0, 1'b0, 0, 1'b0, -1, n);
    do_instr(32'hD3600000, 1'b0, 1'b0, 0, 1'b1, -1, n);
    do_instr(32'h9B000000, 1'b0, 1'b0, 0, 1'b0, -1, n);
    do_instr(32'h91000421, 1'b0, 1'b0, 0, 1'b1, -1, n);
    chk("addi cycle count", n, 4);
    @(negedge clk); #1 rd_cnt = 0;
    do_instr(32'hF8400000, 1'b0, 1'b0, 3, 1'b0, -1, n);
    chk("ldur cycle count", n, 8);
    do_instr(32'h14000001, 1'b0, 1'b0, 0, 1'b0, -1, n);
    @(negedge clk); #1;
    chk("ldur accept to next req", gap, 8);
    chk("ldur mem_read cycles", rd_cnt, 4);
    @(negedge clk); #1 begin pc_cnt = 0; rw_cnt = 0; end
    do_instr(32'hF8000000, 1'b0, 1'b0, 0, 1'b1, -1, n);
    @(negedge clk); #1;
    chk("stur cycle count", n, 4);
    chk("stur pc_write pulses", pc_cnt, 1);
    chk("stur reg_write pulses", rw_cnt, 0);
    do_instr(32'hB4000040, 1'b1, 1'b0, 0, 1'b0, -1, n);
    chk("cbz cycle count", n, 3);
    do_instr(32'hB4000040, 1'b0, 1'b0, 0, 1'b1, -1, n);
    do_instr(32'h54000000, 1'b0, 1'b1, 0, 1'b0, -1, n);
    do_instr(32'h54000000, 1'b1, 1'b0, 0, 1'b0, -1, n);
    do_instr(32'hF8000000, 1'b0, 1'b0, 2, 1'b0, -1, n);
    do_instr(32'hF8400000, 1'b0, 1'b0, 5, 1'b0, 1, n);
    #1 chk("dmem_req in mem", 32'(dmem_req), 32'h1);
    reset_n = 1'b0; cur_opc = '0;
    #1;
    chk("dmem_req async drop", 32'(dmem_req), 32'h0);
    chk("outputs after mid-mem reset", 32'(act), 32'h0);
    cycle(mk(1'b0, 1'b0, 1'b1), '0);
    cycle(mk(1'b0, 1'b0, 1'b0), '0);
    reset_n = 1'b1;
    cycle(mk(1'b0, 1'b1, 1'b1), '0);
    idle(1'b1);
    do_instr(32'hAB020020, 1'b0, 1'b0, 0, 1'b0, -1, n);
    stop_fetch();
    idle(1'b1);
    do_instr(32'hFFE00000, 1'b0, 1'b0, 0, 1'b0, -1, n);
    for (int k = 0; k < 10; k++) cycle({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hAB020020}, base());
    chk("illegal sticky", 32'(illegal), 32'h1);
    do_reset();
    idle(1'b1);
    do_instr(32'h14000001, 1'b0, 1'b0, 0, 1'b0, -1, n);
    stop_fetch();
    idle(1'b0);
    repeat (2) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multicycle main control FSM for the LEGv8-subset CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Produces the 2-bit ALUOp and the datapath enables consumed by the ALU control decoder.
- It is the initiator side of the ALUOp/opcode interface. It also owns the instruction-memory and data-memory req/ack handshakes.

Parameters:
- ALUOP_W, 2, width of the ALUOp bus (00 = add for address, 01 = pass-b for compare/branch, 10 = decode from opcode field)
- OPC_W, 11, width of the opcode field instr[31:21]

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  enable; leaving IDLE requires run=1
- instr  in  32  instruction word from IMEM, sampled on the fetch accept cycle
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  IMEM data valid
- dmem_ack  in  1  DMEM access complete
- zero  in  1  ALU zero flag (CBZ)
- cond_true  in  1  B.cond condition evaluated from stored flags
- opcode_field  out  11  latched instr[31:21], drives ALU control
- alu_op  out  2  ALUOp
- reg2loc, alu_src, mem_to_reg, reg_write  out  1 each  datapath selects/enables
- dmem_req, mem_read, mem_write  out  1 each  DMEM request and direction
- ir_write, pc_write, pc_branch, flags_write  out  1 each  one-cycle update strobes
- illegal  out  1  sticky unknown-opcode indicator

Behaviour:
- **Reset.** Reset is asynchronous and active-low, with one clock. While reset_n=0:
  - state = IDLE
  - IR = 0, opcode_field = 0
  - illegal = 0
  - every output = 0
- **Output timing.** Outputs are decoded from state and the latched instruction class (Moore). Only state, IR and illegal are registers.
- **IDLE.** All outputs 0. Goes to FETCH when run=1.
- **FETCH.**
  - imem_req=1 and is held until imem_ack.
  - On the cycle imem_ack=1: ir_write=1, IR <= instr, state goes to DECODE.
  - run=0 while waiting returns the FSM to IDLE only if imem_ack=0 that cycle.
- **DECODE** (1 cycle). The classifier maps IR[31:21] to a class:
  - RTYPE: ADDS, SUBS, AND, LSR, LSL, MUL
  - ADDI: 1001000100x
  - LOAD: LDUR 11111000010
  - STORE: STUR 11111000000
  - CBZ: 10110100xxx
  - BCOND: 01010100xxx
  - B: 000101xxxxx
  - ILL: anything else

  ILL goes to HALT and sets illegal=1. Every other class goes to EXEC.
- **EXEC** (1 cycle):
  - RTYPE: alu_op=10, reg2loc=0, alu_src=0. flags_write=1 for ADDS/SUBS only. Then WB.
  - ADDI: alu_op=10, alu_src=1. Then WB.
  - LOAD/STORE: alu_op=00, alu_src=1. STORE also sets reg2loc=1. Then MEM.
  - CBZ: alu_op=01, reg2loc=1, pc_write=1, pc_branch=zero. Then FETCH.
  - BCOND: pc_write=1, pc_branch=cond_true. Then FETCH.
  - B: pc_write=1, pc_branch=1. Then FETCH.
- **MEM.**
  - alu_op=00, alu_src=1, dmem_req=1, with mem_read (LOAD) or mem_write (STORE), all held until dmem_ack.
  - On dmem_ack: LOAD goes to WB. STORE pulses pc_write=1 (pc_branch=0) and goes to FETCH.
- **WB** (1 cycle):
  - reg_write=1, pc_write=1, pc_branch=0.
  - mem_to_reg=1 for LOAD only; alu_op/alu_src are held at their EXEC values.
  - Then FETCH.
- **HALT.** All outputs 0 except illegal=1. Left only by reset.
- **Strobe rule.** pc_write is exactly one cycle per retired instruction. ir_write is exactly one cycle per fetch.
- **Stale acks.** An ack arriving while the FSM is not in the matching state is ignored.
- **Reset mid-transaction.** reset_n falling in FETCH or MEM drops the request the same cycle (asynchronous reset), with no further strobes.
- **Cycle counts** (zero-wait acks):
  - R-type/ADDI: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branches: 3 cycles

Decomposition:
- Package cpu_ctrl_pkg:
  - state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT)
  - instruction class enum
  - opcode constants and wildcard patterns
  - ALUOP_ADD=00, ALUOP_PASSB=01, ALUOP_RTYPE=10
- Sub-module opcode_classifier: purely combinational, 11-bit opcode -> class. It is reused by the verification scoreboard.

Test Plan:
- **ADDS.** Reset, run=1, zero-wait acks, instr=0xAB020020 (ADDS).
  - Required sequence: FETCH, DECODE, EXEC, WB.
  - EXEC: alu_op=10, flags_write=1. WB: reg_write=1, pc_write=1.
  - opcode_field=11'b10101011000.
- **LDUR with DMEM wait.** instr opcode 11111000010; dmem_ack delayed 3 cycles.
  - dmem_req=1 and mem_read=1 are held 4 cycles in MEM.
  - WB: mem_to_reg=1, reg_write=1.
  - 8 cycles from fetch accept to the next imem_req.
- **STUR.** opcode 11111000000.
  - EXEC: reg2loc=1.
  - MEM: mem_write=1.
  - reg_write never asserts; pc_write pulses exactly once.
- **CBZ.** Run twice, once with zero=1 and once with zero=0.
  - EXEC: alu_op=01, pc_write=1, pc_branch=1 (zero=1) or 0 (zero=0).
  - Next state is FETCH in both cases.
- **Illegal opcode.** opcode 11111111111.
  - HALT entered after DECODE; illegal=1 and stays set across 10 cycles with run=1 and imem_ack=1.
  - Cleared only by reset_n=0.
- **Mid-transaction reset and stale acks.**
  - Assert reset_n=0 mid-MEM: dmem_req drops asynchronously, state=IDLE, all outputs 0.
  - A stale dmem_ack pulse in IDLE has no effect.
